// File: rtl/regfile_sb.sv
// Integer register file with a per-register busy scoreboard for in-order issue.
// Define RF_BYPASS_EN to forward same-cycle writeback data/busy to the read ports.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRP  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRP*$clog2(NREG)-1:0] rd_addr,
  output logic [NRP*XLEN-1:0]      rd_data,
  output logic [NRP-1:0]           rd_busy,
  input  logic                     wr_en,
  input  logic [$clog2(NREG)-1:0]  wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     iss_en,
  input  logic [$clog2(NREG)-1:0]  iss_addr,
  output logic                     iss_ok,
  input  logic                     flush,
  output logic [$clog2(NREG+1)-1:0] busy_cnt
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = $clog2(NREG+1);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   busy_cnt_q, busy_cnt_d;
  logic            wr_act;

  assign wr_act = wr_en & (wr_addr != '0);

  // A writeback to the issue target in the same cycle frees it, so issue may proceed.
  assign iss_ok = rst | (~flush & ((iss_addr == '0) | ~busy_q[iss_addr] |
                                   (wr_en & (wr_addr == iss_addr))));

  always_comb begin
    busy_d = busy_q;
    if (wr_act) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else if (iss_en && iss_ok && (iss_addr != '0)) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Register 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_act) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = rd_addr[p*AW +: AW];

`ifdef RF_BYPASS_EN
    assign hit = ~rst & wr_act & (wr_addr == addr);
`else
    assign hit = 1'b0;
`endif

    assign rd_data[p*XLEN +: XLEN] = rst ? '0 : (hit ? wr_data : regs_q[addr]);
    assign rd_busy[p]              = ~rst & ~hit & busy_q[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (XLEN=32, NREG=32, NRP=2).
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_ok;
  logic        flush;
  logic [5:0]  busy_cnt;

  int total = 0;
  int bad   = 0;

  regfile_sb #(.XLEN(32), .NREG(32), .NRP(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_ok   (iss_ok),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
    idle();
    #12;
    check("rst_cnt", 64'(busy_cnt), 64'd0);
    check("rst_ok", 64'(iss_ok), 64'd1);
    check("rst_rd", rd_data, 64'd0);
    rst = 1'b0;
    tick();

    // write x5, read x5 and x0
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle();
    rd(5'd5, 5'd0);
    check("rd_x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("rd_x0", 64'(rd_data[63:32]), 64'd0);
    // writes to x0 ignored
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    tick();
    idle();
    rd(5'd0, 5'd5);
    check("x0_wr_ign", 64'(rd_data[31:0]), 64'd0);

    // issue x7 twice
    iss_en = 1'b1; iss_addr = 5'd7;
    #1;
    check("iss7_ok", 64'(iss_ok), 64'd1);
    tick();
    check("iss7_reok", 64'(iss_ok), 64'd0);
    check("iss7_cnt", 64'(busy_cnt), 64'd1);
    rd(5'd7, 5'd0);
    check("iss7_busy", 64'(rd_busy), 64'b01);
    tick();
    check("stall_cnt", 64'(busy_cnt), 64'd1);

    // same-cycle writeback and issue of x7
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
    #1;
    check("wbiss_ok", 64'(iss_ok), 64'd1);
    tick();
    idle();
    rd(5'd7, 5'd7);
    check("wbiss_data", 64'(rd_data[31:0]), 64'h12);
    check("wbiss_busy", 64'(rd_busy), 64'b11);
    check("wbiss_cnt", 64'(busy_cnt), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
    tick();
    idle();
    check("wb7_cnt", 64'(busy_cnt), 64'd0);

    // issue to x0 never marks busy
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle();
    check("iss0_cnt", 64'(busy_cnt), 64'd0);

    // three issues then flush with issue x4 and writeback x10
    for (int i = 1; i <= 3; i++) begin
      iss_en = 1'b1; iss_addr = 5'(i);
      tick();
    end
    check("three_cnt", 64'(busy_cnt), 64'd3);
    flush = 1'b1; iss_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAB;
    #1;
    check("flush_ok", 64'(iss_ok), 64'd0);
    tick();
    idle();
    check("flush_cnt", 64'(busy_cnt), 64'd0);
    rd(5'd4, 5'd10);
    check("flush_x4", 64'(rd_busy), 64'd0);
    check("flush_wb", 64'(rd_data[63:32]), 64'hAB);

    // same-cycle write/read of x9
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
    tick();
    idle();
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    rd(5'd9, 5'd9);
`ifdef RF_BYPASS_EN
    check("byp_data", rd_data, {32'h55, 32'h55});
    check("byp_busy", 64'(rd_busy), 64'b00);
`else
    check("byp_data", rd_data, {32'h11, 32'h11});
    check("byp_busy", 64'(rd_busy), 64'b11);
`endif
    tick();
    idle();
    #1;
    check("x9_after", rd_data, {32'h55, 32'h55});
    check("x9_busy", 64'(rd_busy), 64'b00);
    check("x9_cnt", 64'(busy_cnt), 64'd0);

    // async reset mid-stall with three busy registers
    for (int i = 1; i <= 3; i++) begin
      iss_en = 1'b1; iss_addr = 5'(i);
      tick();
    end
    iss_addr = 5'd1;
    rd(5'd5, 5'd10);
    check("pre_rst_cnt", 64'(busy_cnt), 64'd3);
    check("pre_rst_ok", 64'(iss_ok), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_cnt", 64'(busy_cnt), 64'd0);
    check("arst_rd", rd_data, 64'd0);
    check("arst_busy", 64'(rd_busy), 64'd0);
    check("arst_ok", 64'(iss_ok), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFF;
    tick();
    check("rst_wr_ign", rd_data, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_x5", 64'(rd_data[31:0]), 64'd0);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77;
    iss_en = 1'b1; iss_addr = 5'd1;
    #1;
    check("post_rst_ok", 64'(iss_ok), 64'd1);
    tick();
    idle();
    #1;
    check("post_rst_wr", 64'(rd_data[31:0]), 64'h77);
    check("post_rst_cnt", 64'(busy_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, 4..64.
REQ-003 SHALL have parameter NRP, default 2, number of read ports, 1..4.
REQ-004 SHALL derive AW = clog2(NREG) and CW = clog2(NREG+1) internally.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 rd_addr  in  NRP*AW  packed read addresses; port i uses bits [i*AW +: AW].
REQ-008 rd_data  out  NRP*XLEN  packed read data, combinational from rd_addr.
REQ-009 rd_busy  out  NRP  scoreboard busy bit for each read address.
REQ-010 wr_en  in  1  writeback strobe.
REQ-011 wr_addr  in  AW  writeback destination.
REQ-012 wr_data  in  XLEN  writeback value.
REQ-013 iss_en  in  1  issue request; marks iss_addr busy if accepted.
REQ-014 iss_addr  in  AW  destination of issuing instruction.
REQ-015 iss_ok  out  1  combinational; issue is accepted this cycle.
REQ-016 flush  in  1  clears all busy bits (pipeline squash).
REQ-017 busy_cnt  out  CW  registered count of busy registers.

Function
REQ-018 Register 0 SHALL read as 0, ignore writes, never be busy, and always give iss_ok=1 when not flushing.
REQ-019 Reads SHALL be asynchronous; each port is independent, and any number of ports MAY address the same register.
REQ-020 When wr_en=1 and wr_addr!=0, the register SHALL take wr_data at the rising edge, and its busy bit SHALL clear.
REQ-021 iss_ok SHALL equal !flush & (iss_addr==0 | !busy[iss_addr] | (wr_en & wr_addr==iss_addr)).
REQ-022 When iss_en & iss_ok & iss_addr!=0, busy[iss_addr] SHALL set at the rising edge.
REQ-023 When issue and writeback target the same register in one cycle, busy SHALL end at 1 (set wins) and data SHALL take wr_data.
REQ-024 When iss_en=1 and iss_ok=0, busy SHALL be unchanged (stall; the requester holds its request).
REQ-025 flush=1 SHALL clear every busy bit at the edge, ignore iss_en that cycle, and still perform any writeback.
REQ-026 busy_cnt SHALL equal the population count of the busy vector after each edge; it never exceeds NREG-1.
REQ-027 rd_busy[i] SHALL equal busy[rd_addr_i], subject to REQ-032.

Reset
REQ-028 rst=1 SHALL immediately clear all registers to 0, all busy bits to 0, and busy_cnt to 0, independent of clk.
REQ-029 During rst, rd_data SHALL read 0, rd_busy 0, and iss_ok 1; wr_en and iss_en SHALL be ignored.
REQ-030 Reset asserted mid-stall SHALL discard all in-flight busy state; the first edge after deassertion SHALL behave normally.

Configuration
REQ-031 Macro RF_BYPASS_EN SHALL select write-to-read bypass.
REQ-032 With RF_BYPASS_EN defined, a read port whose address equals wr_addr, with wr_en=1 and wr_addr!=0, SHALL return wr_data and rd_busy=0 in the same cycle.
REQ-033 Without RF_BYPASS_EN, such a read SHALL return the stored value and the stored busy bit; the new value is visible from the next cycle.

Verification
REQ-034 Reset, then write x5=0xDEADBEEF, then read x5 and x0 on ports 0 and 1 -> 0xDEADBEEF and 0x00000000.
REQ-035 Issue x7, then re-issue x7 the next cycle -> iss_ok=0 on the second cycle, busy_cnt=1, rd_busy=1 when reading x7.
REQ-036 With x7 busy, drive wr_en x7=0x12 and iss_en x7 in the same cycle -> iss_ok=1, x7=0x12, busy remains 1, busy_cnt=1.
REQ-037 Issue x1, x2, and x3 on consecutive cycles, then flush together with iss_en x4 -> busy_cnt=0 after the flush edge, and x4 not busy.
REQ-038 Write x9=0x55 while reading x9 (old value 0x11) -> 0x55 and rd_busy=0 with RF_BYPASS_EN; 0x11 and the stored busy bit without it.
REQ-039 Assert rst asynchronously between edges with busy_cnt=3 -> busy_cnt=0 and all reads 0 before the next clk edge.
